// File: rtl/mult_pkg.sv
// Shared types and elaboration helpers for the
// sequential multiply-accumulate unit.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  function automatic bit step_ok(int w, int s);
    return (w >= 4) && (w % 2 == 0) &&
           (s == 1 || s == 2 || s == 4) &&
           (w % s == 0);
  endfunction

  function automatic int out_width(int w);
    return 2 * w;
  endfunction

  function automatic int n_steps(int w, int s);
    return w / s;
  endfunction

endpackage

// File: rtl/mult_pp_step.sv
// One shift-add step: retires STEP multiplier bits,
// most significant first, into the accumulator.
module mult_pp_step
  import mult_pkg::*;
#(
  parameter int IN_WIDTH = 32,
  parameter int STEP = 1,
  localparam int OUT_WIDTH = out_width(IN_WIDTH)
) (
  input  logic [IN_WIDTH-1:0]  mcand,
  input  logic [STEP-1:0]      mbits,
  input  logic [OUT_WIDTH-1:0] acc_in,
  output logic [OUT_WIDTH-1:0] acc_out
);

  always_comb begin
    acc_out = acc_in << STEP;
    for (int i = 0; i < STEP; i++) begin
      if (mbits[i]) begin
        acc_out = acc_out + (OUT_WIDTH'(mcand) << i);
      end
    end
  end

endmodule

// File: rtl/mult_acc.sv
// Sequential (A*B + C) unit: magnitude shift-add
// multiply, then sign fix-up and addend in one cycle.
module mult_acc
  import mult_pkg::*;
#(
  parameter int IN_WIDTH = 32,
  parameter int STEP = 1,
  localparam int OUT_WIDTH = out_width(IN_WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IN_WIDTH-1:0]  data_multiplicand,
  input  logic [IN_WIDTH-1:0]  data_multiplier,
  input  logic [OUT_WIDTH-1:0] data_addend,
  input  logic                 ctrl_signed,
  input  logic                 ctrl_enable,
  output logic [OUT_WIDTH-1:0] data_result,
  output logic                 ctrl_done,
  output logic                 ctrl_busy
);

  localparam int N = n_steps(IN_WIDTH, STEP);
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  generate
    if (!step_ok(IN_WIDTH, STEP)) begin : g_bad_cfg
      $fatal(1, "mult_acc: illegal IN_WIDTH/STEP");
    end
  endgenerate

  state_t state, state_n;

  logic [IN_WIDTH-1:0]  mcand, mplier;
  logic [OUT_WIDTH-1:0] addend, acc, acc_nxt;
  logic [OUT_WIDTH-1:0] fixed;
  logic [CW-1:0]        cnt;
  logic                 neg;
  logic                 a_neg, b_neg;
  logic [IN_WIDTH-1:0]  a_mag, b_mag;

  mult_pp_step #(
    .IN_WIDTH(IN_WIDTH),
    .STEP(STEP)
  ) u_step (
    .mcand  (mcand),
    .mbits  (mplier[IN_WIDTH-1 -: STEP]),
    .acc_in (acc),
    .acc_out(acc_nxt)
  );

  always_comb begin
    a_neg = ctrl_signed & data_multiplicand[IN_WIDTH-1];
    b_neg = ctrl_signed & data_multiplier[IN_WIDTH-1];
    a_mag = a_neg ? -data_multiplicand
                  : data_multiplicand;
    b_mag = b_neg ? -data_multiplier
                  : data_multiplier;
    fixed = (neg ? -acc : acc) + addend;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (ctrl_enable) state_n = CALC;
      CALC: if (cnt == LAST) state_n = FIX;
      FIX:  state_n = DONE;
      DONE: if (!ctrl_enable) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ctrl_done <= 1'b0;
      ctrl_busy <= 1'b0;
    end else begin
      state     <= state_n;
      ctrl_done <= (state_n == DONE);
      ctrl_busy <= (state_n == CALC) ||
                   (state_n == FIX);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand       <= '0;
      mplier      <= '0;
      addend      <= '0;
      acc         <= '0;
      cnt         <= '0;
      neg         <= 1'b0;
      data_result <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (ctrl_enable) begin
            mcand  <= a_mag;
            mplier <= b_mag;
            addend <= data_addend;
            neg    <= a_neg ^ b_neg;
            acc    <= '0;
            cnt    <= '0;
          end
        end
        CALC: begin
          acc    <= acc_nxt;
          mplier <= mplier << STEP;
          cnt    <= cnt + CW'(1);
        end
        FIX: data_result <= fixed;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_acc.sv
// Scoreboard bench: two mult_acc instances (STEP 1
// and 4) share stimulus and are checked by monitors.
module tb_mult_acc;

  localparam int W = 32;
  localparam int N1 = 32;
  localparam int N4 = 8;

  typedef struct {
    logic [63:0] r;
    int          cap;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic [63:0]   c = '0;
  logic          sgn = 1'b0;
  logic          en = 1'b0;
  logic [63:0]   res1, res4;
  logic          done1, done4, busy1, busy4;

  int vectors = 0;
  int miscompares = 0;
  int ncnt = 0;
  int dn1 = 0;
  int dn4 = 0;
  logic pd1 = 1'b0;
  logic pd4 = 1'b0;
  exp_t q1[$];
  exp_t q4[$];

  mult_acc #(.IN_WIDTH(W), .STEP(1)) dut1 (
    .clk(clk), .rst(rst),
    .data_multiplicand(a),
    .data_multiplier(b),
    .data_addend(c),
    .ctrl_signed(sgn),
    .ctrl_enable(en),
    .data_result(res1),
    .ctrl_done(done1),
    .ctrl_busy(busy1)
  );

  mult_acc #(.IN_WIDTH(W), .STEP(4)) dut4 (
    .clk(clk), .rst(rst),
    .data_multiplicand(a),
    .data_multiplier(b),
    .data_addend(c),
    .ctrl_signed(sgn),
    .ctrl_enable(en),
    .data_result(res4),
    .ctrl_done(done4),
    .ctrl_busy(busy4)
  );

  always #5 clk = ~clk;
  always @(posedge clk) ncnt++;

  function automatic logic [63:0] model(
    input logic [W-1:0] x,
    input logic [W-1:0] y,
    input logic [63:0]  z,
    input logic         s
  );
    longint unsigned px, py;
    px = s ? {{32{x[W-1]}}, x} : {32'b0, x};
    py = s ? {{32{y[W-1]}}, y} : {32'b0, y};
    return px * py + z;
  endfunction

  task automatic chk(
    input string       nm,
    input logic [63:0] act,
    input logic [63:0] want
  );
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s: got %h want %h",
               nm, act, want);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && done1 && !pd1) begin
      if (q1.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_done1: got 1 want 0");
      end else begin
        e = q1.pop_front();
        chk("result1", res1, e.r);
        chk("latency1", 64'(ncnt - e.cap),
            64'(N1 + 1));
      end
      dn1++;
    end
    pd1 = done1;
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && done4 && !pd4) begin
      if (q4.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_done4: got 1 want 0");
      end else begin
        e = q4.pop_front();
        chk("result4", res4, e.r);
        chk("latency4", 64'(ncnt - e.cap),
            64'(N4 + 1));
      end
      dn4++;
    end
    pd4 = done4;
  end

  task automatic start(
    input logic [W-1:0] x,
    input logic [W-1:0] y,
    input logic [63:0]  z,
    input logic         s,
    input bit           push1
  );
    exp_t e;
    a = x;
    b = y;
    c = z;
    sgn = s;
    en = 1'b1;
    e.r = model(x, y, z, s);
    e.cap = ncnt + 1;
    if (push1) q1.push_back(e);
    q4.push_back(e);
  endtask

  task automatic scramble();
    a = $urandom;
    b = $urandom;
    c = {$urandom, $urandom};
    sgn = 1'($urandom);
  endtask

  // mode 0: drop enable after done
  // mode 1: hold enable past done
  // mode 2: drop enable while calculating
  task automatic run_op(
    input logic [W-1:0] x,
    input logic [W-1:0] y,
    input logic [63:0]  z,
    input logic         s,
    input int           mode
  );
    int d1, d4;
    bit ok;
    d1 = dn1;
    d4 = dn4;
    start(x, y, z, s, 1'b1);
    @(negedge clk); #1;
    scramble();
    if (mode == 2) begin
      repeat (2) begin
        @(negedge clk); #1;
      end
      en = 1'b0;
    end
    ok = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if (dn1 > d1 && dn4 > d4) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk); #1;
    end
    if (!ok) begin
      vectors++;
      miscompares++;
      $display("FAIL timeout: got no done want done");
    end
    if (mode == 1) begin
      repeat (3) begin
        @(negedge clk); #1;
        scramble();
        chk("hold_done1", 64'(done1), 64'd1);
        chk("hold_done4", 64'(done4), 64'd1);
        chk("hold_busy1", 64'(busy1), 64'd0);
        chk("hold_busy4", 64'(busy4), 64'd0);
      end
    end
    if (mode == 2) begin
      @(negedge clk); #1;
      chk("pulse_done1", 64'(done1), 64'd0);
      chk("pulse_done4", 64'(done4), 64'd0);
    end else begin
      en = 1'b0;
      @(negedge clk); #1;
    end
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_res1", res1, 64'd0);
    chk("rst_res4", res4, 64'd0);
    chk("rst_done1", 64'(done1), 64'd0);
    chk("rst_done4", 64'(done4), 64'd0);
    chk("rst_busy1", 64'(busy1), 64'd0);
    chk("rst_busy4", 64'(busy4), 64'd0);
    rst = 1'b0;
    @(negedge clk); #1;

    // abort the STEP=1 unit mid-CALC
    start(32'd9, 32'd9, 64'd0, 1'b0, 1'b0);
    repeat (12) begin
      @(negedge clk); #1;
    end
    chk("mid_busy1", 64'(busy1), 64'd1);
    rst = 1'b1;
    en = 1'b0;
    @(negedge clk); #1;
    chk("abort_res1", res1, 64'd0);
    chk("abort_done1", 64'(done1), 64'd0);
    chk("abort_busy1", 64'(busy1), 64'd0);
    chk("abort_done4", 64'(done4), 64'd0);
    rst = 1'b0;
    run_op(32'd3, 32'd4, 64'd0, 1'b0, 0);

    run_op(32'd7, 32'd5, 64'd0, 1'b0, 1);
    repeat (10) @(negedge clk);
    #1;
    run_op(32'd500, 32'd111, 64'd0, 1'b0, 0);
    run_op(32'd1664525, 32'd1,
           64'd1013904223, 1'b0, 2);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF,
           64'd0, 1'b0, 0);
    run_op(-32'sd7, 32'd5, 64'd0, 1'b1, 0);
    run_op(32'h8000_0000, 32'h8000_0000,
           64'd0, 1'b1, 0);
    run_op(32'h8000_0000, 32'h8000_0000,
           64'd0, 1'b0, 0);
    run_op(32'd0, 32'hDEAD_BEEF,
           64'h1234_5678_9ABC_DEF0, 1'b1, 0);
    run_op(32'hFFFF_FFFF, 32'd1,
           64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1);

    for (int i = 0; i < 30; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 7 == 0) ra = 32'h8000_0000;
      if (i % 11 == 0) rb = '0;
      run_op(ra, rb, {$urandom, $urandom},
             1'($urandom),
             int'($urandom_range(0, 2)));
    end

    repeat (5) @(negedge clk);
    #1;
    chk("q1_empty", 64'(q1.size()), 64'd0);
    chk("q4_empty", 64'(q4.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mult_acc.md
MULT_ACC -- requirements
Module: mult_acc

Interface
REQ-001 Parameter: IN_WIDTH, default 32, operand width; even, >= 4.
REQ-002 Parameter: STEP, default 1, multiplier bits retired per cycle; legal 1, 2, 4; must divide IN_WIDTH.
REQ-003 Derived constants: OUT_WIDTH = 2*IN_WIDTH; N = IN_WIDTH/STEP.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 data_multiplicand  input  IN_WIDTH  operand A.
REQ-007 data_multiplier  input  IN_WIDTH  operand B.
REQ-008 data_addend  input  OUT_WIDTH  accumulate term C.
REQ-009 ctrl_signed  input  1  1 = A, B two's complement; 0 = unsigned.
REQ-010 ctrl_enable  input  1  start request, level-held by requester.
REQ-011 data_result  output  OUT_WIDTH  (A*B + C) mod 2^OUT_WIDTH.
REQ-012 ctrl_done  output  1  result valid.
REQ-013 ctrl_busy  output  1  operation in progress (CALC or FIX).

Function
REQ-014 FSM states IDLE, CALC, FIX, DONE; registered outputs only.
REQ-015 IDLE: ctrl_enable=1 at an edge captures A, B, C, ctrl_signed; next state CALC.
REQ-016 Signed mode: operands converted to magnitudes at capture; product sign = sign(A) XOR sign(B) stored.
REQ-017 CALC: shift-add, STEP multiplier bits per cycle, exactly N cycles, then FIX.
REQ-018 FIX: one cycle; conditional two's-complement negate of product, then add C modulo 2^OUT_WIDTH; write data_result; next state DONE.
REQ-019 ctrl_done rises exactly N+1 edges after the capture edge (N+2 cycles total incl. capture).
REQ-020 DONE: ctrl_done=1 while ctrl_enable=1; ctrl_enable=0 -> IDLE, ctrl_done=0 next edge.
REQ-021 New operation requires ctrl_enable low for >= 1 edge after DONE; no back-to-back restart while held high.
REQ-022 ctrl_enable dropped during CALC/FIX: ignored; operation completes, DONE lasts one cycle, then IDLE.
REQ-023 Input changes after capture edge have no effect on the current result.
REQ-024 data_result changes only at FIX->DONE; holds its value in IDLE, CALC and DONE.
REQ-025 ctrl_busy = 1 in CALC and FIX only.
REQ-026 Signed -2^(IN_WIDTH-1) * -2^(IN_WIDTH-1) yields exact 2^(2*IN_WIDTH-2); no overflow.
REQ-027 Zero operand yields C with identical latency; no early termination.

Reset
REQ-028 rst=1 at an edge: state IDLE, data_result=0, ctrl_done=0, ctrl_busy=0, internal registers cleared.
REQ-029 Reset mid-operation (CALC/FIX/DONE) aborts without writing data_result; rst has priority over ctrl_enable.
REQ-030 ctrl_enable high on the first edge after rst falls starts an operation normally.

Structure
REQ-031 Package mult_pkg: state enum type, STEP legality check, OUT_WIDTH/N derivation functions.
REQ-032 One sub-module mult_pp_step: combinational STEP-bit partial-product add (multiplicand, STEP multiplier bits, accumulator in -> accumulator out), instantiated once.
REQ-033 Illegal STEP/IN_WIDTH combination shall fail at elaboration.

Verification
REQ-034 Unsigned, IN_WIDTH=32, STEP=1: A=7, B=5, C=0 -> result 35; ctrl_done high 33 edges after capture.
REQ-035 Unsigned: A=500, B=111, C=0, enable after 100 ns idle -> 55500; STEP=4 run -> same result, done 9 edges after capture.
REQ-036 LCG step: A=1664525, B=1, C=1013904223 -> 1015568748; A=B=0xFFFFFFFF, C=0 -> 0xFFFFFFFE00000001.
REQ-037 Signed: A=-7, B=5 -> 0xFFFFFFFFFFFFFFDD; A=B=0x80000000 -> 0x4000000000000000; same A,B unsigned -> 0x4000000000000000.
REQ-038 rst asserted at CALC cycle 10 -> next edge done=0, busy=0, result unchanged (0); restart A=3, B=4 -> 12.
REQ-039 Enable held high after done -> done stays 1, no restart; enable dropped in CALC -> one-cycle done pulse, correct result.
